neuron_sum: RTL and testbench

NEURON_SUM -- requirements
Module: neuron_sum

---
 rtl/neuron_sum.sv | 162 ++++++++++++++++
 tb/tb_neuron_sum.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_sum.sv
// Single neuron: weighted sum of N Q0.8 inputs with one serial weight-update pass per delta.
// Argument is ready 1 cycle after the Nth input; UPD takes N cycles (N+1 with NEURON_SUM_BIAS_EN).
// Inputs are refused outside ACC and deltas outside DEL; the argument holds until accepted.
module neuron_sum #(
    parameter int N     = 4,
    parameter int SHIFT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        train,
    input  logic        input_valid,
    input  logic [7:0]  input_data,
    output logic        input_ready,
    output logic        argument_valid,
    output logic [15:0] argument_data,
    input  logic        argument_ready,
    input  logic        delta_valid,
    input  logic [15:0] delta_data,
    output logic        delta_ready
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {ACC, ARG, DEL, UPD} state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic [7:0]         x_reg [N];
    logic signed [15:0] w [N];
    logic signed [31:0] acc;
    logic signed [15:0] delta_reg;

    logic signed [24:0] prod_in;
    logic signed [24:0] prod_upd;
    logic signed [31:0] acc_next;
    logic signed [31:0] acc_base;
    logic signed [15:0] w_upd;
    logic               last_idx;

`ifdef NEURON_SUM_BIAS_EN
    logic signed [15:0] bias;
    logic               bias_phase;
    logic signed [24:0] prod_bias;
    logic signed [15:0] bias_upd;
`endif

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'sh7fff;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    always_comb begin
        prod_in  = 25'(w[idx]) * 25'($signed({1'b0, input_data}));
        acc_next = acc + 32'(prod_in);
        prod_upd = 25'(delta_reg) * 25'($signed({1'b0, x_reg[idx]}));
        w_upd    = sat16(32'(w[idx]) + 32'(prod_upd >>> SHIFT));
        last_idx = (idx == IW'(N - 1));
`ifdef NEURON_SUM_BIAS_EN
        prod_bias = 25'(delta_reg) * 25'sd255;
        bias_upd  = sat16(32'(bias) + 32'(prod_bias >>> SHIFT));
        acc_base  = 32'(bias) <<< 8;
`else
        acc_base  = '0;
`endif
    end

    assign input_ready = (state == ACC);
    assign delta_ready = (state == DEL);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ACC;
            idx            <= '0;
            acc            <= '0;
            argument_valid <= 1'b0;
            argument_data  <= '0;
            delta_reg      <= '0;
            for (int i = 0; i < N; i++) begin
                w[i]     <= '0;
                x_reg[i] <= '0;
            end
`ifdef NEURON_SUM_BIAS_EN
            bias       <= '0;
            bias_phase <= 1'b0;
`endif
        end else begin
            case (state)
                ACC: begin
                    if (input_valid) begin
                        x_reg[idx] <= input_data;
                        acc        <= acc_next;
                        if (last_idx) begin
                            argument_data  <= sat16(acc_next >>> 8);
                            argument_valid <= 1'b1;
                            idx            <= '0;
                            state          <= ARG;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ARG: begin
                    // train only matters in the handshake cycle
                    if (argument_ready) begin
                        argument_valid <= 1'b0;
                        if (train) begin
                            state <= DEL;
                        end else begin
                            acc   <= acc_base;
                            idx   <= '0;
                            state <= ACC;
                        end
                    end
                end
                DEL: begin
                    if (delta_valid) begin
                        delta_reg <= delta_data;
                        idx       <= '0;
                        state     <= UPD;
                    end
                end
                UPD: begin
`ifdef NEURON_SUM_BIAS_EN
                    if (bias_phase) begin
                        bias       <= bias_upd;
                        bias_phase <= 1'b0;
                        acc        <= 32'(bias_upd) <<< 8;
                        idx        <= '0;
                        state      <= ACC;
                    end else begin
                        w[idx] <= w_upd;
                        if (last_idx)
                            bias_phase <= 1'b1;
                        else
                            idx <= idx + 1'b1;
                    end
`else
                    w[idx] <= w_upd;
                    if (last_idx) begin
                        acc   <= '0;
                        idx   <= '0;
                        state <= ACC;
                    end else begin
                        idx <= idx + 1'b1;
                    end
`endif
                end
                default: begin
                    acc            <= acc_base;
                    idx            <= '0;
                    argument_valid <= 1'b0;
                    state          <= ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_sum.sv
// Directed and random passes through neuron_sum, checked against an integer model of the neuron.
module tb_neuron_sum;

    localparam int N     = 4;
    localparam int SHIFT = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        train;
    logic        input_valid;
    logic [7:0]  input_data;
    logic        input_ready;
    logic        argument_valid;
    logic [15:0] argument_data;
    logic        argument_ready;
    logic        delta_valid;
    logic [15:0] delta_data;
    logic        delta_ready;

    int          vectors     = 0;
    int          miscompares = 0;
    int          mw [N];
    int          mx [N];
    logic [15:0] last_arg;

    neuron_sum #(.N(N), .SHIFT(SHIFT)) dut (
        .clock          (clock),
        .reset          (reset),
        .train          (train),
        .input_valid    (input_valid),
        .input_data     (input_data),
        .input_ready    (input_ready),
        .argument_valid (argument_valid),
        .argument_data  (argument_data),
        .argument_ready (argument_ready),
        .delta_valid    (delta_valid),
        .delta_data     (delta_data),
        .delta_ready    (delta_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int msat(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) mw[i] = 0;
    endtask

    task automatic send(input int x);
        int n;
        n = 0;
        input_valid = 1'b1;
        input_data  = 8'(x);
        while (!input_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("input_ready_timeout", 32'd0, 32'd1);
        tick();
        input_valid = 1'b0;
        input_data  = 8'($urandom);
    endtask

    // One full pass: N inputs, argument handshake after 'hold' stalled cycles, optional update.
    task automatic run_pass(input bit tr, input logic [15:0] d, input int hold);
        int          s;
        int          n;
        int          dd;
        logic [15:0] exp;
        s = 0;
        for (int i = 0; i < N; i++) s += mw[i] * mx[i];
        exp = 16'(msat(s >>> 8));
        for (int i = 0; i < N; i++) begin
            train = 1'($urandom);
            send(mx[i]);
        end
        chk("arg_valid_rise", 32'(argument_valid), 32'd1);
        chk("arg_data", 32'(argument_data), 32'(exp));
        last_arg = argument_data;
        for (int k = 0; k < hold; k++) begin
            train = 1'($urandom);
            tick();
            chk("hold_data", 32'(argument_data), 32'(exp));
            chk("hold_valid", 32'(argument_valid), 32'd1);
            chk("hold_input_ready", 32'(input_ready), 32'd0);
        end
        train          = tr;
        argument_ready = 1'b1;
        tick();
        argument_ready = 1'b0;
        train          = 1'($urandom);
        chk("arg_valid_drop", 32'(argument_valid), 32'd0);
        if (tr) begin
            chk("delta_ready_in_del", 32'(delta_ready), 32'd1);
            chk("input_ready_in_del", 32'(input_ready), 32'd0);
            delta_valid = 1'b1;
            delta_data  = d;
            tick();
            delta_valid = 1'b0;
            delta_data  = 16'($urandom);
            n = 0;
            while (!input_ready && n < N + 10) begin
                tick();
                n++;
            end
            chk("upd_cycles", 32'(n), 32'(N));
            dd = int'($signed(d));
            for (int i = 0; i < N; i++) mw[i] = msat(mw[i] + ((dd * mx[i]) >>> SHIFT));
        end else begin
            chk("back_to_acc", 32'(input_ready), 32'd1);
            chk("no_delta_ready", 32'(delta_ready), 32'd0);
        end
    endtask

    task automatic set_all(input int x);
        for (int i = 0; i < N; i++) mx[i] = x;
    endtask

    initial begin
        reset          = 1'b1;
        train          = 1'b0;
        input_valid    = 1'b0;
        input_data     = '0;
        argument_ready = 1'b0;
        delta_valid    = 1'b0;
        delta_data     = '0;
        last_arg       = '0;
        do_reset();

        chk("reset_arg_valid", 32'(argument_valid), 32'd0);
        chk("reset_input_ready", 32'(input_ready), 32'd1);
        chk("reset_delta_ready", 32'(delta_ready), 32'd0);

        set_all(255);
        run_pass(1'b0, 16'h0000, 0);
        chk("zero_weights_arg", 32'(last_arg), 32'h0000);

        run_pass(1'b1, 16'h0100, 2);
        run_pass(1'b0, 16'h0000, 0);
        chk("trained_arg", 32'(last_arg), 32'h03F8);

        run_pass(1'b1, 16'hFF00, 0);
        run_pass(1'b0, 16'h0000, 0);
        chk("untrained_arg", 32'(last_arg), 32'h0000);

        for (int i = 0; i < N; i++) mx[i] = $urandom_range(0, 255);
        run_pass(1'b1, 16'($urandom), 0);
        for (int i = 0; i < N; i++) mx[i] = $urandom_range(0, 255);
        run_pass(1'b0, 16'h0000, 5);

        // Reset after 2 inputs: later updates must line up with indices 0..N-1 again
        train = 1'b1;
        send(8'h55);
        send(8'hAA);
        do_reset();
        chk("midpass_arg_valid", 32'(argument_valid), 32'd0);
        chk("midpass_input_ready", 32'(input_ready), 32'd1);
        for (int i = 0; i < N; i++) mx[i] = $urandom_range(1, 255);
        run_pass(1'b1, 16'h4000, 0);
        for (int i = 0; i < N; i++) mx[i] = $urandom_range(0, 255);
        run_pass(1'b0, 16'h0000, 0);

        set_all(255);
        do_reset();
        for (int k = 0; k < 3; k++) run_pass(1'b1, 16'h7FFF, 0);
        run_pass(1'b0, 16'h0000, 0);
        chk("pos_saturation", 32'(last_arg), 32'h7FFF);
        for (int k = 0; k < 4; k++) run_pass(1'b1, 16'h8000, 0);
        run_pass(1'b0, 16'h0000, 0);
        chk("neg_saturation", 32'(last_arg), 32'h8000);

        for (int p = 0; p < 30; p++) begin
            for (int i = 0; i < N; i++) mx[i] = $urandom_range(0, 255);
            run_pass(1'($urandom), 16'($urandom), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
